paralel: RTL and testbench

PARALEL -- requirements
Module: paralel

---
 rtl/paralel.sv | 45 ++++
 tb/tb_paralel.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/paralel.sv
// Serial-in, parallel-out shift register of WIDTH stages, shifting on every clk rise.
// Latency: one clock from d to the entry bit of q, WIDTH clocks to the far-end bit.
// No backpressure: there is no enable or handshake, and bits leaving the far end are dropped.
//
// Ports:
//   clk   - single system clock, rising-edge active
//   reset - asynchronous active-low reset, clears q immediately
//   d     - serial data input, sampled on each rising clk edge
//   q     - parallel register contents, driven straight from the flops
module paralel #(
    parameter int unsigned WIDTH      = 5,
    parameter bit          SHIFT_LEFT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // SHIFT_LEFT=1: new bit enters q[0] and data moves toward the MSB.
    // SHIFT_LEFT=0: new bit enters q[WIDTH-1] and data moves toward the LSB.
    // The far-end bit falls off in both cases.
    always_comb begin
        q_d = q_q;
        if (SHIFT_LEFT) begin
            q_d = {q_q[WIDTH-2:0], d};
        end else begin
            q_d = {d, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_paralel.sv
module tb_paralel;

    logic       clk;
    logic       reset;
    logic       d;
    logic       d_r;
    logic [4:0] q_l;
    logic [4:0] q_r;

    int total;
    int bad;

    typedef struct {
        logic [4:0] el;
        logic [4:0] er;
        string      name;
    } exp_t;

    exp_t sb[$];

    paralel #(.WIDTH(5), .SHIFT_LEFT(1'b1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q_l)
    );

    paralel #(.WIDTH(5), .SHIFT_LEFT(1'b0)) dut_r (
        .clk   (clk),
        .reset (reset),
        .d     (d_r),
        .q     (q_r)
    );

    // Period 50 ns, first rising edge at 25 ns.
    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive one serial bit to each instance, queue the values q must show after
    // the next rising edge, then advance to the following falling edge.
    task automatic step(input logic dl, input logic dr,
                        input logic [4:0] el, input logic [4:0] er, input string name);
        exp_t e;
        d   = dl;
        d_r = dr;
        e.el   = el;
        e.er   = er;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, pop one expectation if one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_left"},  q_l, e.el);
                check({e.name, "_right"}, q_r, e.er);
            end
        end
    end

    initial begin
        logic [4:0] ser_l [10];
        logic       ser_d [10];
        total = 0;
        bad   = 0;
        reset = 1'b0;
        d     = 1'b1;
        d_r   = 1'b1;

        // Reset held low across the first edge with d=1.
        @(posedge clk);
        #1;
        check("reset_edge_left",  q_l, 5'b00000);
        check("reset_edge_right", q_r, 5'b00000);

        // Release at 50 ns and shift the serial pattern in.
        @(negedge clk);
        reset = 1'b1;
        ser_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ser_l = '{5'b00001, 5'b00011, 5'b00110, 5'b01101, 5'b11010,
                  5'b10101, 5'b01010, 5'b10100, 5'b01001, 5'b10010};
        for (int i = 0; i < 10; i++) begin
            step(ser_d[i], 1'b0, ser_l[i], 5'b00000, $sformatf("serial%0d", i));
        end

        // Now at 550 ns with q_l=10010; pull reset low midway at 570 ns.
        d = 1'b1;
        #20;
        reset = 1'b0;
        #1;
        check("async_clr_left",  q_l, 5'b00000);
        check("async_clr_right", q_r, 5'b00000);
        step(1'b1, 1'b1, 5'b00000, 5'b00000, "held_reset_a");
        step(1'b1, 1'b1, 5'b00000, 5'b00000, "held_reset_b");

        // Release at 650 ns: left saturates with ones, right walks a single one.
        reset = 1'b1;
        step(1'b1, 1'b1, 5'b00001, 5'b10000, "sat0");
        step(1'b1, 1'b0, 5'b00011, 5'b01000, "sat1");
        step(1'b1, 1'b0, 5'b00111, 5'b00100, "sat2");
        step(1'b1, 1'b0, 5'b01111, 5'b00010, "sat3");
        step(1'b1, 1'b0, 5'b11111, 5'b00001, "sat4");
        step(1'b1, 1'b0, 5'b11111, 5'b00000, "sat5");
        step(1'b1, 1'b0, 5'b11111, 5'b00000, "sat6");

        // Toggle d between edges; only the value present at the edge counts.
        d = 1'b1; d_r = 1'b0;
        #5 d = 1'b0; d_r = 1'b1;
        #5 d = 1'b1; d_r = 1'b0;
        #5;
        check("glitch_hold_left",  q_l, 5'b11111);
        check("glitch_hold_right", q_r, 5'b00000);
        #3;
        step(1'b0, 1'b1, 5'b11110, 5'b10000, "glitch_a");

        d = 1'b0; d_r = 1'b1;
        #5 d = 1'b1; d_r = 1'b0;
        #5 d = 1'b0; d_r = 1'b1;
        #5;
        check("glitch_hold2_left",  q_l, 5'b11110);
        check("glitch_hold2_right", q_r, 5'b10000);
        #5;
        step(1'b1, 1'b0, 5'b11101, 5'b01000, "glitch_b");

        // Mid-sequence reset discards everything stored.
        #10;
        reset = 1'b0;
        #1;
        check("midseq_clr_left",  q_l, 5'b00000);
        check("midseq_clr_right", q_r, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        check("midseq_stay_left",  q_l, 5'b00000);
        check("midseq_stay_right", q_r, 5'b00000);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
